seq_det_ctrl: RTL and testbench
===============================

# seq_det_ctrl

Programmable serial sequence-detection controller. It arms a Moore-style pattern scan on a serial bit stream with a runtime pattern of 1..MAX_LEN bits and overlapping or non-overlapping matching. It counts matches up to a programmed target and reports completion through a start/busy/done handshake. It sits between the register/config layer and the serial data source, replacing fixed-pattern detectors such as the 10110 FSM.

## Interface
- MAX_LEN, 8: maximum pattern length in bits.
- CNT_W, 8: match counter / target width.
- TO_W, 16: timeout counter width (used only with SEQ_DET_TIMEOUT_EN).
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a scan; ignored while busy.
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is the first bit received.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length; 0 is treated as 1, >MAX_LEN clamps to MAX_LEN.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping matching.
- cfg_target  in  CNT_W  matches to DONE; 0 = free-running (no DONE from matches).
- cfg_timeout  in  TO_W  valid bits without a match before abort; 0 = disabled.
- data  in  1  serial bit.
- data_valid  in  1  data is sampled only when high.
- busy  out  1  high in SCAN/HIT.
- detected  out  1  Moore output; high for the cycle in HIT or DONE-by-match.
- match_cnt  out  CNT_W  matches since the last start; held after DONE.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  qualifies done: scan aborted by timeout.

## Operation
- States:
  - IDLE: outputs low.
  - SCAN: busy.
  - HIT: busy, detected.
  - DONE: done; detected if the exit was by match; timeout if the exit was by timeout.
- IDLE + start: latch config, clear history/fill/match_cnt/timeout counter, go to SCAN.
- SCAN/HIT with data_valid: shift data into the history LSB, fill = min(fill+1, MAX_LEN).
- Match: hist[len-1:0] == pattern[len-1:0] and fill >= len, evaluated on the post-shift value.
- On match:
  - match_cnt increments, saturating at all ones.
  - If the new count equals a nonzero target, go to DONE; otherwise go to HIT.
  - Non-overlap mode clears fill to 0. Overlap mode leaves fill unchanged.
- SCAN/HIT with no match on the edge: go to SCAN. This includes data_valid low.
- DONE always goes to IDLE next cycle.
- A start pulse in SCAN/HIT/DONE is ignored; latched config is stable for the entire scan.
- Reset in any state: IDLE, history/fill/counters zero, all outputs 0 on the next edge.

## Timing
- Reset values: busy=0, detected=0, match_cnt=0, done=0, timeout=0.
- start sampled at edge E: busy high from E; the first bit is accepted at edge E+1.
- Match on the bit sampled at edge k: detected (and done, if target reached) high during cycle k..k+1; match_cnt updated at edge k.
- Back-to-back matches in overlap mode (e.g. pattern 11, stream 111): HIT→HIT, so detected stays high for consecutive cycles.
- All outputs are registered state decodes; there is no combinational path from data to outputs.

## Configuration
- SEQ_DET_TIMEOUT_EN defined:
  - A TO_W counter clears at start and on each match, and increments on each valid non-matching bit.
  - When it reaches a nonzero cfg_timeout, go to DONE with done=1, timeout=1, detected=0.
  - A match on the same bit takes priority over timeout.
- SEQ_DET_TIMEOUT_EN undefined: no counter; cfg_timeout is ignored; timeout is tied 0.

## Structure
- Package seq_det_pkg holds:
  - the state typedef (IDLE=2'b00, SCAN=2'b01, HIT=2'b10, DONE=2'b11);
  - the default MAX_LEN/CNT_W/TO_W constants.
- Sub-module seq_det_shifter holds the history register, fill counter and length-masked compare. Its inputs are shift, clear and clear_fill; its output is match.
- The top level holds the FSM, the counters and the config latch.

## Test plan
- Config len=5, pattern=5'b10110, overlap=1, target=2; stream 1,0,1,1,0,1,1,0 -> detected after bits 5 and 8, match_cnt=2, done+detected together on bit 8, busy=0 the next cycle.
- Same stream with overlap=0, target=2 -> one match (bit 5), match_cnt=1, no done, busy stays 1.
- Overlap case with data_valid low for 3 cycles between bits 2 and 3 -> identical match positions (counted in valid bits), no spurious detected.
- Second start mid-scan carrying a different pattern -> ignored; detection follows the originally latched pattern.
- Reset asserted after 3 valid bits -> next edge busy=0, match_cnt=0; after a new start, a full 5-bit pattern is required before detected.
- SEQ_DET_TIMEOUT_EN on, cfg_timeout=4, target=1, stream 0,0,0,0 -> done=1, timeout=1, match_cnt=0 on bit 4. With the macro off -> busy remains 1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the programmable sequence detector.
package seq_det_pkg;
    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int TO_W_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        HIT  = 2'b10,
        DONE = 2'b11
    } state_e;
endpackage

// File: rtl/seq_det_shifter.sv
// Serial history register, fill counter and length-masked pattern compare.
// match looks at the post-shift history, so it is only meaningful while shift is high.
module seq_det_shifter
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift,
    input  logic               clear,
    input  logic               clear_fill,
    input  logic               data,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    output logic               match
);
    logic [MAX_LEN-1:0] hist_q, hist_d, mask;
    logic [LEN_W-1:0]   fill_q, fill_inc;

    always_comb begin
        hist_d   = {hist_q[MAX_LEN-2:0], data};
        fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        match = shift && (((hist_d ^ pattern) & mask) == '0) && (fill_inc >= len);
    end

    // clear_fill restarts the window after a non-overlapping match
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift) begin
            hist_q <= hist_d;
            fill_q <= clear_fill ? '0 : fill_inc;
        end
    end
endmodule

// File: rtl/seq_det_ctrl.sv
// Sequence-detection controller: FSM, match/timeout counters and config latch.
// Optional abort-on-timeout feature enabled by defining SEQ_DET_TIMEOUT_EN.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = MAX_LEN_DEF,
    parameter  int CNT_W   = CNT_W_DEF,
    parameter  int TO_W    = TO_W_DEF,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TO_W-1:0]    cfg_timeout,
    input  logic               data,
    input  logic               data_valid,
    output logic               busy,
    output logic               detected,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               done,
    output logic               timeout
);
    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q, len_eff;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q, cnt_q, cnt_d;
    logic               hitx_q, hitx_d, tox_q, tox_d;
    logic               latch, sh_clear, clear_fill, shift, match;

    assign shift = data_valid && (state_q == SCAN || state_q == HIT);

    always_comb begin
        len_eff = cfg_len;
        if (cfg_len == '0)                       len_eff = LEN_W'(1);
        else if (cfg_len > LEN_W'(MAX_LEN))      len_eff = LEN_W'(MAX_LEN);
    end

    seq_det_shifter #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .shift     (shift),
        .clear     (sh_clear),
        .clear_fill(clear_fill),
        .data      (data),
        .len       (len_q),
        .pattern   (pat_q),
        .match     (match)
    );

`ifdef SEQ_DET_TIMEOUT_EN
    logic [TO_W-1:0] tmo_q, to_cnt_q, to_cnt_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^cfg_timeout;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hitx_d     = hitx_q;
        tox_d      = tox_q;
        latch      = 1'b0;
        sh_clear   = 1'b0;
        clear_fill = 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SCAN;
                    latch    = 1'b1;
                    sh_clear = 1'b1;
                    cnt_d    = '0;
                    hitx_d   = 1'b0;
                    tox_d    = 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            SCAN, HIT: begin
                clear_fill = match && !ovl_q;
                if (match) begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
`ifdef SEQ_DET_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    if (tgt_q != '0 && cnt_d == tgt_q) begin
                        state_d = DONE;
                        hitx_d  = 1'b1;
                    end else begin
                        state_d = HIT;
                    end
                end else begin
                    state_d = SCAN;
`ifdef SEQ_DET_TIMEOUT_EN
                    // a match on the same bit already took the branch above
                    if (shift) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                        if (tmo_q != '0 && to_cnt_d == tmo_q) begin
                            state_d = DONE;
                            tox_d   = 1'b1;
                        end
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= LEN_W'(1);
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            hitx_q  <= 1'b0;
            tox_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hitx_q  <= hitx_d;
            tox_q   <= tox_d;
            if (latch) begin
                pat_q <= cfg_pattern;
                len_q <= len_eff;
                ovl_q <= cfg_overlap;
                tgt_q <= cfg_target;
            end
        end
    end

`ifdef SEQ_DET_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q    <= '0;
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            if (latch) tmo_q <= cfg_timeout;
        end
    end
`endif

    assign busy      = (state_q == SCAN) || (state_q == HIT);
    assign detected  = (state_q == HIT) || (state_q == DONE && hitx_q);
    assign done      = (state_q == DONE);
    assign timeout   = (state_q == DONE) && tox_q;
    assign match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_seq_det_ctrl;
    localparam int MAXL = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0, data = 1'b0, data_valid = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = '0;
    logic [15:0] cfg_timeout = '0;
    logic       busy, detected, done, timeout;
    logic [7:0] match_cnt;

    int n_chk = 0, n_err = 0;

    seq_det_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
        .data(data), .data_valid(data_valid),
        .busy(busy), .detected(detected), .match_cnt(match_cnt),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // reference model: observable outputs plus the received-bit window
    bit       m_busy, m_det, m_done, m_to;
    int       m_cnt, m_tocnt;
    bit       q[$];
    bit [7:0] ml_pat;
    int       ml_len, ml_tgt, ml_tmo;
    bit       ml_ovl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit st, input bit d, input bit v);
        bit hit;
        int n;
        if (rst) begin
            m_busy = 0; m_det = 0; m_done = 0; m_to = 0;
            m_cnt = 0; m_tocnt = 0; q.delete();
        end else if (m_done) begin
            m_done = 0; m_det = 0; m_to = 0;
        end else if (!m_busy) begin
            m_det = 0;
            if (st) begin
                ml_pat = cfg_pattern;
                ml_len = (cfg_len == 0) ? 1 : ((cfg_len > MAXL) ? MAXL : int'(cfg_len));
                ml_ovl = cfg_overlap;
                ml_tgt = cfg_target;
                ml_tmo = cfg_timeout;
                m_busy = 1; m_cnt = 0; m_tocnt = 0; q.delete();
            end
        end else begin
            m_det = 0;
            if (v) begin
                q.push_back(d);
                if (q.size() > MAXL) void'(q.pop_front());
                n = q.size();
                hit = (n >= ml_len);
                if (hit)
                    for (int i = 0; i < ml_len; i++)
                        if (q[n-1-i] != ml_pat[i]) hit = 0;
                if (hit) begin
                    if (m_cnt < 255) m_cnt++;
                    m_tocnt = 0;
                    if (!ml_ovl) q.delete();
                    m_det = 1;
                    if (ml_tgt != 0 && m_cnt == ml_tgt) begin
                        m_busy = 0; m_done = 1;
                    end
                end else begin
                    m_tocnt++;
`ifdef SEQ_DET_TIMEOUT_EN
                    if (ml_tmo != 0 && m_tocnt == ml_tmo) begin
                        m_busy = 0; m_done = 1; m_to = 1;
                    end
`endif
                end
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit st, input bit d, input bit v);
        reset = rst; start = st; data = d; data_valid = v;
        model_step(rst, st, d, v);
        @(posedge clk);
        @(negedge clk);
        chk("busy", busy, m_busy);
        chk("detected", detected, m_det);
        chk("done", done, m_done);
        chk("timeout", timeout, m_to);
        chk("match_cnt", match_cnt, m_cnt);
    endtask

    task automatic setcfg(input bit [7:0] p, input bit [3:0] l, input bit o,
                          input bit [7:0] t, input bit [15:0] tm);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t; cfg_timeout = tm;
    endtask

    task automatic bit_in(input bit d);
        cycle(0, 0, d, 1);
    endtask

    bit stream [8] = '{1, 0, 1, 1, 0, 1, 1, 0};

    initial begin
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", match_cnt, 0);

        // overlap, target 2: hits on bits 5 and 8, done on 8
        setcfg(8'b10110, 5, 1, 2, 0);
        cycle(0, 1, 0, 0);
        chk("s1_busy_start", busy, 1);
        for (int i = 0; i < 8; i++) begin
            bit_in(stream[i]);
            if (i == 4) chk("s1_det5", detected, 1);
        end
        chk("s1_done", done, 1);
        chk("s1_det8", detected, 1);
        chk("s1_cnt", match_cnt, 2);
        cycle(0, 0, 0, 0);
        chk("s1_busy_after", busy, 0);
        chk("s1_cnt_held", match_cnt, 2);

        // non-overlap: only one match, scan continues
        setcfg(8'b10110, 5, 0, 2, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) bit_in(stream[i]);
        chk("s2_cnt", match_cnt, 1);
        chk("s2_busy", busy, 1);
        chk("s2_done", done, 0);
        cycle(1, 0, 0, 0);

        // invalid gap between bits 2 and 3
        setcfg(8'b10110, 5, 1, 2, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) for (int g = 0; g < 3; g++) cycle(0, 0, 1, 0);
            bit_in(stream[i]);
        end
        chk("s3_done", done, 1);
        chk("s3_cnt", match_cnt, 2);
        cycle(0, 0, 0, 0);

        // second start mid-scan with another pattern is ignored
        setcfg(8'b10110, 5, 1, 0, 0);
        cycle(0, 1, 0, 0);
        bit_in(1); bit_in(0);
        setcfg(8'b00111, 3, 0, 1, 0);
        cycle(0, 1, 1, 1);
        bit_in(1); bit_in(0);
        chk("s4_det", detected, 1);
        chk("s4_cnt", match_cnt, 1);
        chk("s4_busy", busy, 1);

        // reset mid-scan, then a full pattern is required again
        setcfg(8'b10110, 5, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        bit_in(1); bit_in(0); bit_in(1);
        cycle(1, 0, 0, 0);
        chk("s5_busy", busy, 0);
        chk("s5_cnt", match_cnt, 0);
        cycle(0, 1, 0, 0);
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        chk("s5_det4", detected, 0);
        bit_in(0);
        chk("s5_det5", detected, 1);
        cycle(1, 0, 0, 0);

        // timeout scenario
        setcfg(8'b10110, 5, 1, 1, 4);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) bit_in(0);
`ifdef SEQ_DET_TIMEOUT_EN
        chk("s6_done", done, 1);
        chk("s6_to", timeout, 1);
        chk("s6_det", detected, 0);
        chk("s6_cnt", match_cnt, 0);
`else
        chk("s6_busy", busy, 1);
        chk("s6_done", done, 0);
`endif
        cycle(1, 0, 0, 0);

        // random episodes
        for (int e = 0; e < 60; e++) begin
            setcfg(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
                   8'($urandom_range(0, 3)), 16'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) < 3) cfg_len = 4'($urandom_range(1, 3));
            cycle(0, 1, 0, 0);
            for (int c = 0; c < 50; c++) begin
                cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
                      1'($urandom), $urandom_range(0, 99) < 70);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
